// File: rtl/pipe_buf.sv
// ---------------------------------------------------------------------------
// pipe_buf : elastic pipeline register between two CPU pipeline stages.
//
// A DEPTH-entry FIFO of opaque WIDTH-bit payloads with a valid/ready
// handshake on both sides, a synchronous flush for redirects, and an
// all-zero payload whenever the buffer is empty, so that downstream
// control fields decode as a NOP bubble.
//
// Ports
//   clk        in   1      rising-edge clock
//   resetn     in   1      asynchronous active-low reset
//   in_valid   in   1      upstream presents a payload
//   in_ready   out  1      buffer has a free entry
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      head entry is valid
//   out_ready  in   1      downstream consumes the head (low = stall)
//   out_data   out  WIDTH  head payload, zero when out_valid is low
//   flush      in   1      discard every entry on the next edge
//   count      out  CW     occupancy, 0..DEPTH
//
// Handshake: a beat moves across a side on a rising edge exactly when that
// side's valid and ready are both high in the preceding cycle and flush is
// low. in_ready and out_valid are decoded from registered occupancy only, so
// neither depends combinationally on the opposite side, and a full buffer
// never passes a beat straight through. Upstream may drop or change in_valid
// and in_data while in_ready is low.
// ---------------------------------------------------------------------------
module pipe_buf #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CW-1:0]    count
);

    // Pointers need at least one bit even when DEPTH is 1.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rp_q, rp_d;
    logic [PW-1:0]    wp_q, wp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push, pop;

    assign in_ready  = (cnt_q != FULL_CNT);
    assign out_valid = (cnt_q != '0);
    assign out_data  = out_valid ? mem_q[rp_q] : '0;
    assign count     = cnt_q;

    // Flush wins over both sides: the beat offered during a flush cycle is
    // dropped and the head is not counted as consumed.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        rp_d  = rp_q;
        wp_d  = wp_q;
        cnt_d = cnt_q;
        if (flush) begin
            rp_d  = '0;
            wp_d  = '0;
            cnt_d = '0;
        end else begin
            // Explicit wrap compare: DEPTH need not be a power of two.
            if (push) begin
                wp_d = (wp_q == LAST_IDX) ? '0 : wp_q + PW'(1);
            end
            if (pop) begin
                rp_d = (rp_q == LAST_IDX) ? '0 : rp_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rp_q  <= '0;
            wp_q  <= '0;
            cnt_q <= '0;
        end else begin
            rp_q  <= rp_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage carries no reset: emptiness is tracked by cnt_q and
    // out_data is masked to zero while empty, so stale contents never leak.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_buf.sv
// ---------------------------------------------------------------------------
// tb_pipe_buf : bench for pipe_buf.
//
// Three instances share clk/resetn: index g has DEPTH = g+1 (1, 2, 3), all
// WIDTH = 64. A per-instance monitor keeps an expected queue fed by the
// beats the bench offers and the DUT accepts, and pops/compares whenever the
// DUT hands a beat downstream. Directed checks in the stimulus process cover
// the hand-computed values of each scenario.
// ---------------------------------------------------------------------------
module tb_pipe_buf;

    logic        clk;
    logic        resetn;
    logic        iv   [3];
    logic        ir   [3];
    logic [63:0] id   [3];
    logic        ov   [3];
    logic        ordy [3];
    logic [63:0] od   [3];
    logic        fl   [3];
    logic [1:0]  cnt_v[3];

    int pass_cnt  = 0;
    int total_cnt = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, pass=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- DUTs + scoreboards ----------------
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [$clog2(g + 2)-1:0] cnt_w;
        logic [63:0]              exp_q[$];

        assign cnt_v[g] = 2'(cnt_w);

        pipe_buf #(.WIDTH(64), .DEPTH(g + 1)) u_dut (
            .clk       (clk),
            .resetn    (resetn),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_data   (id[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_data  (od[g]),
            .flush     (fl[g]),
            .count     (cnt_w)
        );

        always @(negedge resetn) exp_q.delete();

        // Sampled mid-cycle: inputs were driven just after the rising edge.
        always @(negedge clk) begin
            if (resetn) begin
                check($sformatf("d%0d count", g + 1), 64'(cnt_v[g]), 64'(exp_q.size()));
                check($sformatf("d%0d out_valid", g + 1), 64'(ov[g]), 64'(exp_q.size() != 0));
                if (!ov[g]) begin
                    check($sformatf("d%0d bubble data", g + 1), od[g], 64'h0);
                end
                if (fl[g]) begin
                    exp_q.delete();
                end else begin
                    if (ov[g] && ordy[g]) begin
                        if (exp_q.size() == 0) begin
                            check($sformatf("d%0d unexpected beat", g + 1), od[g], 64'hx);
                        end else begin
                            check($sformatf("d%0d out_data", g + 1), od[g], exp_q.pop_front());
                        end
                    end
                    if (iv[g] && ir[g]) begin
                        exp_q.push_back(id[g]);
                    end
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            iv[k]   = 1'b0;
            id[k]   = 64'h0;
            ordy[k] = 1'b0;
            fl[k]   = 1'b0;
        end
    endtask

    // Wrap pattern for the DEPTH=3 instance: {in_valid, out_ready} per cycle.
    logic [1:0] wrap_pat [16] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b01, 2'b11, 2'b11, 2'b01,
                                  2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11};

    // ---------------- stimulus ----------------
    initial begin
        int accepted;
        resetn = 1'b0;
        idle_all();

        // Reset, then idle.
        #2;
        for (int k = 0; k < 3; k++) begin
            check("rst out_valid", 64'(ov[k]), 64'h0);
            check("rst out_data", od[k], 64'h0);
            check("rst in_ready", 64'(ir[k]), 64'h1);
            check("rst count", 64'(cnt_v[k]), 64'h0);
        end
        step();
        step();
        resetn = 1'b1;
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            check("idle out_valid", 64'(ov[k]), 64'h0);
            check("idle out_data", od[k], 64'h0);
            check("idle in_ready", 64'(ir[k]), 64'h1);
            check("idle count", 64'(cnt_v[k]), 64'h0);
        end

        // Streaming, DEPTH=2.
        ordy[1] = 1'b1;
        iv[1] = 1'b1; id[1] = 64'h11; step();
        check("stream d0", od[1], 64'h11); check("stream c0", 64'(cnt_v[1]), 64'h1);
        id[1] = 64'h22; step();
        check("stream d1", od[1], 64'h22); check("stream c1", 64'(cnt_v[1]), 64'h1);
        id[1] = 64'h33; step();
        check("stream d2", od[1], 64'h33); check("stream c2", 64'(cnt_v[1]), 64'h1);
        iv[1] = 1'b0; step();
        check("stream drained", 64'(cnt_v[1]), 64'h0);

        // Stall / full, DEPTH=2.
        ordy[1] = 1'b0;
        iv[1] = 1'b1; id[1] = 64'hA; step();
        id[1] = 64'hB; step();
        check("full count", 64'(cnt_v[1]), 64'h2);
        check("full in_ready", 64'(ir[1]), 64'h0);
        id[1] = 64'hC; step();
        check("full hold count", 64'(cnt_v[1]), 64'h2);
        check("full hold data", od[1], 64'hA);
        ordy[1] = 1'b1; step();
        check("unstall d0", od[1], 64'hB); check("unstall ready", 64'(ir[1]), 64'h1);
        step();
        check("unstall d1", od[1], 64'hC); check("unstall c1", 64'(cnt_v[1]), 64'h1);
        iv[1] = 1'b0; step();
        check("unstall empty", 64'(cnt_v[1]), 64'h0);

        // Flush collision with a full buffer.
        ordy[1] = 1'b0;
        iv[1] = 1'b1; id[1] = 64'h1; step();
        id[1] = 64'h2; step();
        check("pre-flush count", 64'(cnt_v[1]), 64'h2);
        fl[1] = 1'b1; id[1] = 64'hD; ordy[1] = 1'b1; step();
        fl[1] = 1'b0; iv[1] = 1'b0;
        check("flush count", 64'(cnt_v[1]), 64'h0);
        check("flush out_valid", 64'(ov[1]), 64'h0);
        check("flush out_data", od[1], 64'h0);
        check("flush in_ready", 64'(ir[1]), 64'h1);
        step();
        check("flush no 0xD", 64'(ov[1]), 64'h0);
        // Flush at count=1 with room: the offered beat is still dropped.
        ordy[1] = 1'b0; iv[1] = 1'b1; id[1] = 64'h5; step();
        check("post-flush push", od[1], 64'h5);
        fl[1] = 1'b1; id[1] = 64'h6; step();
        fl[1] = 1'b0; iv[1] = 1'b0;
        check("flush drop 0x6", 64'(cnt_v[1]), 64'h0);
        step();

        // Wrap-around, DEPTH=3.
        for (int c = 0; c < 16; c++) begin
            iv[2]   = wrap_pat[c][1];
            ordy[2] = wrap_pat[c][0];
            id[2]   = 64'h100 + 64'(c);
            step();
        end
        iv[2] = 1'b0; ordy[2] = 1'b1;
        repeat (4) step();
        check("wrap drained", 64'(cnt_v[2]), 64'h0);

        // Async reset mid-stream, DEPTH=1.
        iv[0] = 1'b1; id[0] = 64'h77; step();
        iv[0] = 1'b0;
        check("d1 occupied", 64'(cnt_v[0]), 64'h1);
        check("d1 not ready", 64'(ir[0]), 64'h0);
        #2 resetn = 1'b0;
        #1;
        check("async out_valid", 64'(ov[0]), 64'h0);
        check("async count", 64'(cnt_v[0]), 64'h0);
        check("async in_ready", 64'(ir[0]), 64'h1);
        resetn = 1'b1;
        step();
        ordy[0] = 1'b1; iv[0] = 1'b1;
        accepted = 0;
        for (int c = 0; c < 6; c++) begin
            id[0] = 64'h80 + 64'(c);
            if (ir[0]) accepted++;
            step();
        end
        check("half rate", 64'(accepted), 64'h3);
        iv[0] = 1'b0;
        repeat (2) step();

        check("final q d1", 64'(g_dut[0].exp_q.size()), 64'h0);
        check("final q d2", 64'(g_dut[1].exp_q.size()), 64'h0);
        check("final q d3", 64'(g_dut[2].exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
